nibbler_sequencer: RTL and testbench

- Fetch/execute control unit for the Nibbler 4-bit CPU.
- Owns the 12-bit program counter and fetches 1- or 2-byte instructions from the 8-bit program ROM.
- Decodes each opcode into one-cycle strobes for the accumulator, ALU, RAM and I/O ports, and resolves conditional jumps from the datapath CARRY/ZERO flags.
- Sits between the program ROM and the datapath (A, ALU, RAM, IN_0..2, OUT_0..2) inside NIBBLER.

---
 rtl/nibbler_pkg.sv | 49 ++++
 rtl/nibbler_decode.sv | 53 +++++
 rtl/nibbler_sequencer.sv | 129 ++++++++++++
 tb/tb_nibbler_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibbler_pkg.sv
// Shared Nibbler definitions: opcode, ALU op and sequencer state encodings.
// Used by the sequencer, its decoder and the datapath decoder.
package nibbler_pkg;

  typedef enum logic [3:0] {
    OP_JC   = 4'h0,
    OP_JNC  = 4'h1,
    OP_CMPI = 4'h2,
    OP_CMPM = 4'h3,
    OP_LIT  = 4'h4,
    OP_IN   = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_JZ   = 4'h8,
    OP_JNZ  = 4'h9,
    OP_ADDI = 4'hA,
    OP_ADDM = 4'hB,
    OP_JMP  = 4'hC,
    OP_OUT  = 4'hD,
    OP_NORI = 4'hE,
    OP_NORM = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_NOR  = 2'b10,
    ALU_CMP  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_HALT   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_FETCH2 = 2'b10,
    ST_EXEC   = 2'b11
  } state_t;

  // Port select 3 on IN/OUT addresses no port.
  localparam logic [1:0] PORT_NONE = 2'b11;

  function automatic logic is_two_byte(input opcode_t op);
    case (op)
      OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP,
      OP_CMPM, OP_LD, OP_ST, OP_ADDM, OP_NORM: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nibbler_decode.sv
// Combinational opcode decoder: EXEC-cycle strobes and conditional jump resolution.
// Every output is forced low outside EXEC.
module nibbler_decode
  import nibbler_pkg::*;
(
  input  state_t     state,
  input  opcode_t    opcode,
  input  logic [1:0] port_sel,
  input  logic       carry_in,
  input  logic       zero_in,
  output alu_op_t    alu_op,
  output logic       alu_src_mem,
  output logic       acc_we,
  output logic       flags_we,
  output logic       ram_we,
  output logic       in_re,
  output logic       out_we,
  output logic       jump_taken
);

  always_comb begin
    alu_op      = ALU_PASS;
    alu_src_mem = 1'b0;
    acc_we      = 1'b0;
    flags_we    = 1'b0;
    ram_we      = 1'b0;
    in_re       = 1'b0;
    out_we      = 1'b0;
    jump_taken  = 1'b0;
    if (state == ST_EXEC) begin
      case (opcode)
        OP_JC:   jump_taken = carry_in;
        OP_JNC:  jump_taken = ~carry_in;
        OP_JZ:   jump_taken = zero_in;
        OP_JNZ:  jump_taken = ~zero_in;
        OP_JMP:  jump_taken = 1'b1;
        OP_CMPI: begin alu_op = ALU_CMP; flags_we = 1'b1; end
        OP_CMPM: begin alu_op = ALU_CMP; alu_src_mem = 1'b1; flags_we = 1'b1; end
        OP_LIT:  acc_we = 1'b1;
        OP_LD:   begin alu_src_mem = 1'b1; acc_we = 1'b1; end
        OP_ST:   ram_we = 1'b1;
        OP_IN:   in_re  = (port_sel != PORT_NONE);
        OP_OUT:  out_we = (port_sel != PORT_NONE);
        OP_ADDI: begin alu_op = ALU_ADD; acc_we = 1'b1; flags_we = 1'b1; end
        OP_ADDM: begin alu_op = ALU_ADD; alu_src_mem = 1'b1; acc_we = 1'b1; flags_we = 1'b1; end
        OP_NORI: begin alu_op = ALU_NOR; acc_we = 1'b1; flags_we = 1'b1; end
        OP_NORM: begin alu_op = ALU_NOR; alu_src_mem = 1'b1; acc_we = 1'b1; flags_we = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/nibbler_sequencer.sv
// Nibbler fetch/execute control: PC, instruction latch and HALT/FETCH/FETCH2/EXEC FSM.
// Optional single-step input enabled by defining NIBBLER_SEQ_STEP_EN.
module nibbler_sequencer
  import nibbler_pkg::*;
#(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
`ifdef NIBBLER_SEQ_STEP_EN
  input  logic        step,
`endif
  input  logic [7:0]  rom_data,
  input  logic        carry_in,
  input  logic        zero_in,
  output logic [11:0] rom_addr,
  output logic [3:0]  opcode,
  output logic [3:0]  imm,
  output logic [11:0] mem_addr,
  output logic [1:0]  alu_op,
  output logic        alu_src_mem,
  output logic        acc_we,
  output logic        flags_we,
  output logic        ram_we,
  output logic        in_re,
  output logic        out_we,
  output logic [1:0]  state,
  output logic        halted
);

  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  opcode_t     op_q, op_d;
  logic [3:0]  imm_q, imm_d;
  logic [7:0]  lo_q, lo_d;
  alu_op_t     alu_op_w;
  logic        jump_taken;
  logic        start;

`ifdef NIBBLER_SEQ_STEP_EN
  logic step_r, step_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_r <= 1'b0;
      step_d <= 1'b0;
    end else begin
      step_r <= step;
      step_d <= step_r;
    end
  end

  // A stepped instruction needs no extra state: EXEC returns to HALT while run_en is low.
  assign start = run_en | (step_r & ~step_d);
`else
  assign start = run_en;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_HALT;
      pc_q    <= RESET_PC;
      op_q    <= OP_JC;
      imm_q   <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    imm_d   = imm_q;
    lo_d    = lo_q;
    case (state_q)
      ST_HALT: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        op_d    = opcode_t'(rom_data[7:4]);
        imm_d   = rom_data[3:0];
        pc_d    = pc_q + 12'd1;
        state_d = is_two_byte(opcode_t'(rom_data[7:4])) ? ST_FETCH2 : ST_EXEC;
      end
      ST_FETCH2: begin
        lo_d    = rom_data;
        pc_d    = pc_q + 12'd1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (jump_taken) pc_d = {imm_q, lo_q};
        state_d = run_en ? ST_FETCH : ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  nibbler_decode u_decode (
    .state       (state_q),
    .opcode      (op_q),
    .port_sel    (imm_q[1:0]),
    .carry_in    (carry_in),
    .zero_in     (zero_in),
    .alu_op      (alu_op_w),
    .alu_src_mem (alu_src_mem),
    .acc_we      (acc_we),
    .flags_we    (flags_we),
    .ram_we      (ram_we),
    .in_re       (in_re),
    .out_we      (out_we),
    .jump_taken  (jump_taken)
  );

  assign alu_op   = alu_op_w;
  assign rom_addr = pc_q;
  assign opcode   = op_q;
  assign imm      = imm_q;
  assign mem_addr = {imm_q, lo_q};
  assign state    = state_q;
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Directed bench for nibbler_sequencer: per-opcode vector table plus corner sequences.
// Step tests are compiled in when NIBBLER_SEQ_STEP_EN is defined.
module tb_nibbler_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_en = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  rom_data;
  logic        carry_in = 1'b0;
  logic        zero_in = 1'b0;
  logic [11:0] rom_addr;
  logic [3:0]  opcode;
  logic [3:0]  imm;
  logic [11:0] mem_addr;
  logic [1:0]  alu_op;
  logic        alu_src_mem, acc_we, flags_we, ram_we, in_re, out_we;
  logic [1:0]  state;
  logic        halted;

  logic [7:0]  rom [0:4095];
  assign rom_data = rom[rom_addr];

  logic [7:0] strb;
  assign strb = {alu_op, alu_src_mem, acc_we, flags_we, ram_we, in_re, out_we};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibbler_sequencer #(.RESET_PC(12'h000)) dut (
    .clk         (clk),
    .reset       (reset),
    .run_en      (run_en),
`ifdef NIBBLER_SEQ_STEP_EN
    .step        (step),
`endif
    .rom_data    (rom_data),
    .carry_in    (carry_in),
    .zero_in     (zero_in),
    .rom_addr    (rom_addr),
    .opcode      (opcode),
    .imm         (imm),
    .mem_addr    (mem_addr),
    .alu_op      (alu_op),
    .alu_src_mem (alu_src_mem),
    .acc_we      (acc_we),
    .flags_we    (flags_we),
    .ram_we      (ram_we),
    .in_re       (in_re),
    .out_we      (out_we),
    .state       (state),
    .halted      (halted)
  );

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        c;
    logic        z;
    logic [7:0]  strb;
    int          len;
    logic [11:0] pc;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b0;
    run_en = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    logic seen;

    tbl[0]  = '{8'h47, 8'h00, 1'b0, 1'b0, 8'b0001_0000, 2, 12'h001}; // LIT 7
    tbl[1]  = '{8'hC3, 8'h45, 1'b0, 1'b0, 8'b0000_0000, 3, 12'h345}; // JMP
    tbl[2]  = '{8'h80, 8'h10, 1'b0, 1'b0, 8'b0000_0000, 3, 12'h002}; // JZ, z=0
    tbl[3]  = '{8'h80, 8'h10, 1'b0, 1'b1, 8'b0000_0000, 3, 12'h010}; // JZ, z=1
    tbl[4]  = '{8'hA1, 8'h00, 1'b0, 1'b0, 8'b0101_1000, 2, 12'h001}; // ADDI
    tbl[5]  = '{8'hB2, 8'h34, 1'b0, 1'b0, 8'b0111_1000, 3, 12'h002}; // ADDM
    tbl[6]  = '{8'hE5, 8'h00, 1'b0, 1'b0, 8'b1001_1000, 2, 12'h001}; // NORI
    tbl[7]  = '{8'hF0, 8'h01, 1'b0, 1'b0, 8'b1011_1000, 3, 12'h002}; // NORM
    tbl[8]  = '{8'h23, 8'h00, 1'b0, 1'b0, 8'b1100_1000, 2, 12'h001}; // CMPI
    tbl[9]  = '{8'h31, 8'h22, 1'b0, 1'b0, 8'b1110_1000, 3, 12'h002}; // CMPM
    tbl[10] = '{8'h61, 8'h00, 1'b0, 1'b0, 8'b0011_0000, 3, 12'h002}; // LD
    tbl[11] = '{8'h70, 8'h05, 1'b0, 1'b0, 8'b0000_0100, 3, 12'h002}; // ST
    tbl[12] = '{8'h52, 8'h00, 1'b0, 1'b0, 8'b0000_0010, 2, 12'h001}; // IN 2
    tbl[13] = '{8'h53, 8'h00, 1'b0, 1'b0, 8'b0000_0000, 2, 12'h001}; // IN 3
    tbl[14] = '{8'hD1, 8'h00, 1'b0, 1'b0, 8'b0000_0001, 2, 12'h001}; // OUT 1
    tbl[15] = '{8'hD3, 8'h00, 1'b0, 1'b0, 8'b0000_0000, 2, 12'h001}; // OUT 3
    tbl[16] = '{8'h01, 8'h23, 1'b1, 1'b0, 8'b0000_0000, 3, 12'h123}; // JC, c=1
    tbl[17] = '{8'h01, 8'h23, 1'b0, 1'b0, 8'b0000_0000, 3, 12'h002}; // JC, c=0
    tbl[18] = '{8'h1A, 8'hBC, 1'b0, 1'b0, 8'b0000_0000, 3, 12'hABC}; // JNC, c=0
    tbl[19] = '{8'h1A, 8'hBC, 1'b1, 1'b0, 8'b0000_0000, 3, 12'h002}; // JNC, c=1
    tbl[20] = '{8'h9F, 8'hFF, 1'b0, 1'b0, 8'b0000_0000, 3, 12'hFFF}; // JNZ, z=0
    tbl[21] = '{8'h9F, 8'hFF, 1'b0, 1'b1, 8'b0000_0000, 3, 12'h002}; // JNZ, z=1

    // Reset values
    clear_rom();
    do_reset();
    chk("reset state", 32'(state), 32'h0);
    chk("reset rom_addr", 32'(rom_addr), 32'h000);
    chk("reset opcode", 32'(opcode), 32'h0);
    chk("reset imm", 32'(imm), 32'h0);
    chk("reset mem_addr", 32'(mem_addr), 32'h000);
    chk("reset strobes", 32'(strb), 32'h0);
    chk("reset halted", 32'(halted), 32'h1);

    // Table: one instruction from PC 0, then halt
    for (int v = 0; v < 22; v++) begin
      clear_rom();
      rom[0] = tbl[v].b0;
      rom[1] = tbl[v].b1;
      carry_in = tbl[v].c;
      zero_in  = tbl[v].z;
      do_reset();
      run_en = 1'b1;
      n = 0;
      while (n < 6) begin
        @(posedge clk);
        @(negedge clk);
        n++;
        if (state == 2'b11) break;
        chk($sformatf("v%0d idle strobes c%0d", v, n), 32'(strb), 32'h0);
      end
      chk($sformatf("v%0d latency", v), n, tbl[v].len);
      chk($sformatf("v%0d strobes", v), 32'(strb), 32'(tbl[v].strb));
      chk($sformatf("v%0d opcode", v), 32'(opcode), 32'(tbl[v].b0[7:4]));
      chk($sformatf("v%0d imm", v), 32'(imm), 32'(tbl[v].b0[3:0]));
      if (tbl[v].len == 3)
        chk($sformatf("v%0d mem_addr", v), 32'(mem_addr), 32'({tbl[v].b0[3:0], tbl[v].b1}));
      run_en = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d halted", v), 32'(halted), 32'h1);
      chk($sformatf("v%0d pc after", v), 32'(rom_addr), 32'(tbl[v].pc));
      chk($sformatf("v%0d strobes after", v), 32'(strb), 32'h0);
    end
    carry_in = 1'b0;
    zero_in  = 1'b0;

    // PC wrap: JMP 0xFFF, ADDI at 0xFFF, next fetch from 0x000
    clear_rom();
    rom[12'h000] = 8'hCF;
    rom[12'h001] = 8'hFF;
    rom[12'hFFF] = 8'hA1;
    do_reset();
    run_en = 1'b1;
    seen = 1'b0;
    n = 0;
    while (n < 12) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (state == 2'b01 && rom_addr == 12'hFFF) seen = 1'b1;
      if (state == 2'b11 && opcode == 4'hA) break;
    end
    chk("wrap fetch at fff", 32'(seen), 32'h1);
    chk("wrap exec reached", 32'(state == 2'b11 && opcode == 4'hA), 32'h1);
    chk("wrap addi strobes", 32'(strb), 32'h58);
    @(negedge clk);
    chk("wrap next state", 32'(state), 32'h1);
    chk("wrap next rom_addr", 32'(rom_addr), 32'h000);

    // run_en dropped in FETCH2 of ST: finish it, then halt
    clear_rom();
    rom[0] = 8'h70;
    rom[1] = 8'h05;
    do_reset();
    run_en = 1'b1;
    @(negedge clk);
    chk("st fetch", 32'(state), 32'h1);
    @(negedge clk);
    chk("st fetch2", 32'(state), 32'h2);
    run_en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ram_we) pulses++;
      if (i == 0) chk("st exec ram_we", 32'(ram_we), 32'h1);
    end
    chk("st ram_we pulses", pulses, 1);
    chk("st halted", 32'(halted), 32'h1);
    chk("st pc", 32'(rom_addr), 32'h002);

    // Asynchronous reset in FETCH2 of ST at 0x200
    clear_rom();
    rom[12'h000] = 8'hC2;
    rom[12'h001] = 8'h00;
    rom[12'h200] = 8'h70;
    rom[12'h201] = 8'h05;
    do_reset();
    run_en = 1'b1;
    n = 0;
    while (n < 12 && !(state == 2'b10 && rom_addr == 12'h201)) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("rst reached fetch2", 32'(state == 2'b10 && rom_addr == 12'h201), 32'h1);
    reset = 1'b0;
    #1;
    chk("rst state", 32'(state), 32'h0);
    chk("rst pc", 32'(rom_addr), 32'h000);
    chk("rst mem_addr", 32'(mem_addr), 32'h000);
    chk("rst strobes", 32'(strb), 32'h0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ram_we) pulses++;
    end
    chk("rst no ram_we", pulses, 0);
    chk("rst halted held", 32'(halted), 32'h1);
    run_en = 1'b0;
    reset  = 1'b1;

`ifdef NIBBLER_SEQ_STEP_EN
    // Single step: short pulse runs LIT, held step runs ADDI exactly once
    clear_rom();
    rom[0] = 8'h47;
    rom[1] = 8'hA1;
    do_reset();
    @(negedge clk);
    chk("step idle halted", 32'(halted), 32'h1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (state == 2'b11) pulses++;
    end
    chk("step1 exec count", pulses, 1);
    chk("step1 halted", 32'(halted), 32'h1);
    chk("step1 pc", 32'(rom_addr), 32'h001);
    step = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (state == 2'b11) begin
        pulses++;
        chk("step2 addi strobes", 32'(strb), 32'h58);
      end
    end
    step = 1'b0;
    chk("step2 exec count", pulses, 1);
    chk("step2 halted", 32'(halted), 32'h1);
    chk("step2 pc", 32'(rom_addr), 32'h002);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
